// File: rtl/imm_narrow_packer.sv
// Packs 32-bit immediates into 16-bit beats: one tagged beat for sign-extendable words, high/low beats otherwise.
// Optional accept counters enabled by defining IMM_STATS_EN.
module imm_narrow_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [15:0] half_o,
  output logic        short_o,
  output logic        last_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef IMM_STATS_EN
  ,
  output logic [15:0] short_cnt_o,
  output logic [15:0] long_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY, SHORT, HIGH, LOW} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic [15:0] r_half, w_half_nxt;
  logic        r_short, r_last, r_valid;
  logic        w_xfer, w_ready, w_acc, w_fits;

  assign w_fits  = (data_i[31:15] == '0) || (data_i[31:15] == '1);
  assign w_xfer  = r_valid && ready_i;
  // Final-beat transfer frees the slot in the same cycle, so a new word can follow with no bubble.
  assign w_ready = (r_state == EMPTY) || (w_xfer && r_last);
  assign w_acc   = valid_i && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = w_acc ? data_i : r_word;
    case (r_state)
      EMPTY: if (w_acc) w_state_nxt = w_fits ? SHORT : HIGH;
      HIGH:  if (w_xfer) w_state_nxt = LOW;
      SHORT, LOW: begin
        if (w_xfer) begin
          if (w_acc) w_state_nxt = w_fits ? SHORT : HIGH;
          else       w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    w_half_nxt = r_half;
    case (w_state_nxt)
      SHORT, LOW: w_half_nxt = w_word_nxt[15:0];
      HIGH:       w_half_nxt = w_word_nxt[31:16];
      default:    w_half_nxt = r_half;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= EMPTY;
      r_word  <= '0;
      r_half  <= '0;
      r_short <= 1'b0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_half  <= w_half_nxt;
      r_short <= (w_state_nxt == SHORT);
      r_last  <= (w_state_nxt == SHORT) || (w_state_nxt == LOW);
      r_valid <= (w_state_nxt != EMPTY);
    end
  end

  assign ready_o = w_ready;
  assign half_o  = r_half;
  assign short_o = r_short;
  assign last_o  = r_last;
  assign valid_o = r_valid;

`ifdef IMM_STATS_EN
  logic [15:0] r_short_cnt, r_long_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_short_cnt <= '0;
      r_long_cnt  <= '0;
    end else if (w_acc) begin
      if (w_fits && r_short_cnt != 16'hFFFF) r_short_cnt <= r_short_cnt + 16'd1;
      if (!w_fits && r_long_cnt != 16'hFFFF) r_long_cnt <= r_long_cnt + 16'd1;
    end
  end

  assign short_cnt_o = r_short_cnt;
  assign long_cnt_o  = r_long_cnt;
`endif

endmodule

// File: tb/tb_imm_narrow_packer.sv
// Bench for imm_narrow_packer: table of words feeding a beat scoreboard, plus stall and reset-mid-word sequences.
module tb_imm_narrow_packer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [15:0] half_o;
  logic        short_o, last_o, valid_o;
  logic        ready_i = 1'b0;
`ifdef IMM_STATS_EN
  logic [15:0] short_cnt_o, long_cnt_o;
`endif

  imm_narrow_packer dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .half_o(half_o), .short_o(short_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
`ifdef IMM_STATS_EN
    , .short_cnt_o(short_cnt_o), .long_cnt_o(long_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        sh;
    logic [15:0] hi;
    logic [15:0] lo;
  } vec_t;

  typedef struct {
    logic [15:0] half;
    logic        sh;
    logic        last;
  } beat_t;

  vec_t  vecs[10];
  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  bit    bp_mode = 0;
  int    acc_cyc[10];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Beat monitor: a transfer happens at the next rising edge when valid_o && ready_i here.
  always @(negedge clk_i) begin
    if (rst_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        check("unexpected_beat", {16'h0, half_o}, 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = q.pop_front();
        check("beat", {14'h0, short_o, last_o, half_o}, {14'h0, b.sh, b.last, b.half});
      end
    end
    if (rst_i && valid_o && !last_o) check("ready_in_high", {31'h0, ready_o}, 32'h0);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (bp_mode) ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic push_exp(input vec_t v);
    if (v.sh) q.push_back('{v.lo, 1'b1, 1'b1});
    else begin
      q.push_back('{v.hi, 1'b0, 1'b0});
      q.push_back('{v.lo, 1'b0, 1'b1});
    end
  endtask

  // Holds valid_i high; caller drops it after a stream so consecutive sends are back-to-back.
  task automatic send(input vec_t v, input bit push, output int ac);
    bit got;
    got = 0;
    ac = -1;
    data_i  = v.d;
    valid_i = 1'b1;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk_i);
      if (ready_o) begin
        got = 1;
        ac = cyc;
        if (push) push_exp(v);
      end
      tick();
    end
    if (!got) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && q.size() != 0; t++) tick();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    int ac;
    vec_t v;
    vecs[0] = '{32'h0000_1234, 1'b1, 16'h0000, 16'h1234};
    vecs[1] = '{32'hFFFF_8000, 1'b1, 16'hFFFF, 16'h8000};
    vecs[2] = '{32'h0000_8000, 1'b0, 16'h0000, 16'h8000};
    vecs[3] = '{32'h0000_7FFF, 1'b1, 16'h0000, 16'h7FFF};
    vecs[4] = '{32'hFFFF_8001, 1'b1, 16'hFFFF, 16'h8001};
    vecs[5] = '{32'h0000_0000, 1'b1, 16'h0000, 16'h0000};
    vecs[6] = '{32'h1234_5678, 1'b0, 16'h1234, 16'h5678};
    vecs[7] = '{32'h7FFF_FFFF, 1'b0, 16'h7FFF, 16'hFFFF};
    vecs[8] = '{32'hFFFF_7FFF, 1'b0, 16'hFFFF, 16'h7FFF};
    vecs[9] = '{32'hFFFF_FFFF, 1'b1, 16'hFFFF, 16'hFFFF};

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_half", {16'h0, half_o}, 32'h0);
    check("rst_short_last", {30'h0, short_o, last_o}, 32'h0);
    check("rst_ready", {31'h0, ready_o}, 32'h1);
    rst_i = 1'b1;

    // Full-throughput stream of the whole table.
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i], 1'b1, ac);
      acc_cyc[i] = ac;
    end
    valid_i = 1'b0;
    drain();
    check("short_stream_gap0", acc_cyc[4] - acc_cyc[3], 1);
    check("short_stream_gap1", acc_cyc[5] - acc_cyc[4], 1);
    check("long_after_short_gap", acc_cyc[2] - acc_cyc[1], 1);
    check("after_long_gap", acc_cyc[3] - acc_cyc[2], 2);
    check("idle_half_hold", {16'h0, half_o}, 32'hFFFF);
    check("idle_flags", {30'h0, short_o, last_o}, 32'h0);

    // Same table under random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 10; i++) send(vecs[i], 1'b1, ac);
    valid_i = 1'b0;
    drain();
    bp_mode = 0;

    // Stall: HIGH beat held stable for three cycles.
    ready_i = 1'b0;
    send(vecs[6], 1'b1, ac);
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("stall_half", {15'h0, valid_o, half_o}, {15'h0, 1'b1, 16'h1234});
      tick();
    end
    ready_i = 1'b1;
    drain();

    // Reset after the high beat of a long word: low beat must never appear.
    ready_i = 1'b0;
    v = '{32'hDEAD_BEEF, 1'b0, 16'hDEAD, 16'hBEEF};
    send(v, 1'b0, ac);
    valid_i = 1'b0;
    q.push_back('{16'hDEAD, 1'b0, 1'b0});
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("low_pending", {14'h0, valid_o, last_o, half_o}, {14'h0, 1'b1, 1'b1, 16'hBEEF});
    rst_i = 1'b0;
    #1;
    check("rst_mid_valid", {31'h0, valid_o}, 32'h0);
    check("rst_mid_half", {16'h0, half_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    ready_i = 1'b1;
    repeat (5) tick();
    check("post_rst_ready", {30'h0, ready_o, valid_o}, 32'h2);
    check("dead_popped", q.size(), 0);

`ifdef IMM_STATS_EN
    do_reset();
    check("cnt_rst", {short_cnt_o, long_cnt_o}, 32'h0);
    send(vecs[0], 1'b1, ac);
    send(vecs[6], 1'b1, ac);
    send(vecs[3], 1'b1, ac);
    send(vecs[8], 1'b1, ac);
    send(vecs[9], 1'b1, ac);
    valid_i = 1'b0;
    drain();
    check("cnt_3_2", {short_cnt_o, long_cnt_o}, {16'd3, 16'd2});
    do_reset();
    for (int i = 0; i < 65535; i++) send(vecs[5], 1'b1, ac);
    valid_i = 1'b0;
    drain();
    check("cnt_full", {16'h0, short_cnt_o}, 32'hFFFF);
    send(vecs[5], 1'b1, ac);
    valid_i = 1'b0;
    drain();
    check("cnt_sat", {short_cnt_o, long_cnt_o}, {16'hFFFF, 16'h0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
